display_arbiter: RTL and testbench
==================================

DISPLAY_ARBITER -- requirements
Module: display_arbiter

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16'd50000: minimum grant tenure in clk cycles before preemption; legal range 1..65535.
REQ-002 SHALL have parameter BLANK_CYCLES, default 16'd4: blank gap between owners; legal range 1..65535.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on posedge clk.
REQ-004 SHALL have port reset, input, 1: asynchronous, active-low reset (reset==0 resets).
REQ-005 SHALL have port req, input, 3: req[i] high = requester i wants the 4-digit display.
REQ-006 SHALL have ports data0, data1, data2, input, 16 each: hex value from requester 0/1/2 (nibble 0 = rightmost digit).
REQ-007 SHALL have port grant, output, 3: one-hot or zero, registered; grant[i] = requester i owns the display.
REQ-008 SHALL have port owner, output, 2: index of current/last owner, registered; never 2'b11.
REQ-009 SHALL have port disp_data, output, 16: registered value for the 7-segment digit scanner's data input.
REQ-010 SHALL have port disp_enable, output, 1: registered; drives the digit scanner's enable (0 = all digits dark).

Function
REQ-011 SHALL implement FSM states IDLE, GRANT, BLANK.
REQ-012 SHALL keep last-owner pointer LO (2 bits); round-robin search order LO+1, LO+2, LO (mod 3); first requester with req high wins.
REQ-013 IDLE: grant=0, disp_enable=0; on an edge with any req bit high, SHALL go to GRANT, set grant one-hot to the winner, owner=LO=winner, tenure counter=0.
REQ-014 IDLE with req==0 SHALL remain in IDLE.
REQ-015 GRANT: each edge SHALL load disp_data from data<owner> (1-cycle latency from data input to disp_data) and hold disp_enable=1.
REQ-016 GRANT: tenure counter SHALL increment each cycle, saturating at HOLD_CYCLES (no wrap).
REQ-017 GRANT exit (a): owner's req sampled low -> BLANK on that edge; grant=0 and disp_enable=0 from that edge.
REQ-018 GRANT exit (b): counter == HOLD_CYCLES and any other req bit high -> BLANK (preemption), even if owner req still high.
REQ-019 GRANT with owner req high and either counter < HOLD_CYCLES or no other request SHALL remain in GRANT.
REQ-020 BLANK: grant=0, disp_enable=0, disp_data holds last value; SHALL stay exactly BLANK_CYCLES cycles (blank counter 0..BLANK_CYCLES-1).
REQ-021 BLANK end: any req high -> GRANT to round-robin winner (previous owner may win again only if it is the sole requester); else -> IDLE.
REQ-022 Requests arriving or dropping during BLANK SHALL be ignored except for the sample at the final BLANK edge.
REQ-023 Non-owner req changes during GRANT SHALL not alter disp_data, grant or owner.
REQ-024 grant SHALL never have more than one bit set; disp_enable SHALL equal |grant in every cycle.
REQ-025 Simultaneous owner req drop and tenure expiry SHALL take the REQ-017 path (identical result: BLANK).

Reset
REQ-026 On reset==0, asynchronously: state=IDLE, grant=3'b000, owner=2'd2, LO=2, disp_data=16'h0000, disp_enable=0, both counters 0.
REQ-027 Reset asserted mid-GRANT or mid-BLANK SHALL abort immediately with REQ-026 values; first arbitration after release favours requester 0.
REQ-028 Reset release SHALL take effect on the first posedge clk with reset==1; no grant before that edge.

Verification (HOLD_CYCLES=4, BLANK_CYCLES=2)
REQ-029 After reset, req=3'b111 -> grant=001 at edge 1, disp_data=data0 from edge 2; preempt after 4 GRANT cycles, 2 BLANK cycles, then grant=010, then 100, then 001.
REQ-030 req=3'b010 only, held 100 cycles -> grant=010 and disp_enable=1 continuously; counter saturates, no BLANK.
REQ-031 Owner 0 drops req at cycle 2 of tenure with req[2] high -> BLANK 2 cycles, then grant=100; disp_data frozen at last data0 value during BLANK.
REQ-032 data1 changes 16'h1234 -> 16'hBEEF while requester 1 owns -> disp_data shows 16'hBEEF exactly 1 edge later.
REQ-033 All req drop during BLANK and reassert at final BLANK edge -> grant issued directly from BLANK; if low at final edge -> IDLE, outputs dark.
REQ-034 reset==0 pulse mid-GRANT (owner=1) -> grant=000, disp_enable=0, disp_data=0000 immediately; after release with req=111, grant=001.

Source files
------------

// File: rtl/display_arbiter.sv
// Round-robin arbiter granting a shared 4-digit hex display to one of three requesters,
// with a minimum tenure before preemption and a dark gap between owners.
module display_arbiter #(
  parameter logic [15:0] HOLD_CYCLES  = 16'd50000,
  parameter logic [15:0] BLANK_CYCLES = 16'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  input  logic [15:0] data2,
  output logic [2:0]  grant,
  output logic [1:0]  owner,
  output logic [15:0] disp_data,
  output logic        disp_enable
);

  typedef enum logic [1:0] {IDLE, GRANT, BLANK} state_t;

  state_t      state_q, state_d;
  logic [2:0]  grant_q, grant_d;
  logic [1:0]  owner_q, owner_d;
  logic [15:0] data_q, data_d;
  logic        en_q, en_d;
  logic [15:0] ten_q, ten_d;
  logic [15:0] blk_q, blk_d;

  function automatic logic [1:0] nxt(input logic [1:0] i);
    return (i == 2'd2) ? 2'd0 : i + 2'd1;
  endfunction

  function automatic logic req_at(input logic [2:0] r, input logic [1:0] i);
    case (i)
      2'd0:    return r[0];
      2'd1:    return r[1];
      default: return r[2];
    endcase
  endfunction

  // Search order LO+1, LO+2, LO: the previous owner only wins when it is alone.
  logic [1:0] c1, c2, win;
  logic       any_req, own_req, oth_req;
  logic [15:0] sel_data;

  always_comb begin
    c1      = nxt(owner_q);
    c2      = nxt(c1);
    win     = req_at(req, c1) ? c1 : (req_at(req, c2) ? c2 : owner_q);
    any_req = |req;
    own_req = |(req & grant_q);
    oth_req = |(req & ~grant_q);
    case (owner_q)
      2'd0:    sel_data = data0;
      2'd1:    sel_data = data1;
      default: sel_data = data2;
    endcase
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    data_d  = data_q;
    en_d    = en_q;
    ten_d   = ten_q;
    blk_d   = blk_q;
    case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        en_d    = 1'b0;
        if (any_req) begin
          state_d = GRANT;
          grant_d = 3'b001 << win;
          owner_d = win;
          ten_d   = '0;
          en_d    = 1'b1;
        end
      end
      GRANT: begin
        data_d = sel_data;
        if (ten_q != HOLD_CYCLES) ten_d = ten_q + 16'd1;
        if (!own_req || (ten_q == HOLD_CYCLES && oth_req)) begin
          state_d = BLANK;
          grant_d = 3'b000;
          en_d    = 1'b0;
          blk_d   = '0;
        end
      end
      default: begin
        grant_d = 3'b000;
        en_d    = 1'b0;
        // Requests are only looked at on the last blank edge.
        if (blk_q == BLANK_CYCLES - 16'd1) begin
          if (any_req) begin
            state_d = GRANT;
            grant_d = 3'b001 << win;
            owner_d = win;
            ten_d   = '0;
            en_d    = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end else begin
          blk_d = blk_q + 16'd1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      owner_q <= 2'd2;
      data_q  <= 16'h0000;
      en_q    <= 1'b0;
      ten_q   <= '0;
      blk_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      en_q    <= en_d;
      ten_q   <= ten_d;
      blk_q   <= blk_d;
    end
  end

  assign grant       = grant_q;
  assign owner       = owner_q;
  assign disp_data   = data_q;
  assign disp_enable = en_q;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with HOLD_CYCLES=4, BLANK_CYCLES=2.
module tb_display_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [2:0]  req = 3'b000;
  logic [15:0] data0 = 16'hA000, data1 = 16'hB111, data2 = 16'hC222;
  logic [2:0]  grant;
  logic [1:0]  owner;
  logic [15:0] disp_data;
  logic        disp_enable;

  int total = 0;
  int bad   = 0;

  display_arbiter #(.HOLD_CYCLES(16'd4), .BLANK_CYCLES(16'd2)) dut (
    .clk(clk), .reset(reset), .req(req),
    .data0(data0), .data1(data1), .data2(data2),
    .grant(grant), .owner(owner), .disp_data(disp_data), .disp_enable(disp_enable)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  req;
    logic [2:0]  g;
    logic [1:0]  o;
    logic [15:0] d;
    logic        en;
  } vec_t;

  vec_t tbl[23];

  function automatic vec_t mk(logic [2:0] r, logic [2:0] g, logic [1:0] o, logic [15:0] d, logic en);
    vec_t v;
    v.req = r; v.g = g; v.o = o; v.d = d; v.en = en;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] got, input logic [15:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [2:0] g, input logic [1:0] o,
                         input logic [15:0] d, input logic en);
    chk({nm, ".grant"}, {13'd0, grant}, {13'd0, g});
    chk({nm, ".owner"}, {14'd0, owner}, {14'd0, o});
    chk({nm, ".data"}, disp_data, d);
    chk({nm, ".en"}, {15'd0, disp_enable}, {15'd0, en});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Holds reset across edges with requests pending, then releases mid-cycle.
  task automatic do_reset();
    reset = 1'b0;
    req   = 3'b111;
    tick();
    tick();
    chk_all("reset", 3'b000, 2'd2, 16'h0000, 1'b0);
    reset = 1'b1;
    req   = 3'b000;
  endtask

  initial begin
    // Full rotation under constant contention.
    for (int i = 0; i < 5; i++) tbl[i] = mk(3'b111, 3'b001, 2'd0, (i == 0) ? 16'h0000 : 16'hA000, 1'b1);
    tbl[5]  = mk(3'b111, 3'b000, 2'd0, 16'hA000, 1'b0);
    tbl[6]  = mk(3'b111, 3'b000, 2'd0, 16'hA000, 1'b0);
    tbl[7]  = mk(3'b111, 3'b010, 2'd1, 16'hA000, 1'b1);
    for (int i = 8; i < 12; i++) tbl[i] = mk(3'b111, 3'b010, 2'd1, 16'hB111, 1'b1);
    tbl[12] = mk(3'b111, 3'b000, 2'd1, 16'hB111, 1'b0);
    tbl[13] = mk(3'b111, 3'b000, 2'd1, 16'hB111, 1'b0);
    tbl[14] = mk(3'b111, 3'b100, 2'd2, 16'hB111, 1'b1);
    for (int i = 15; i < 19; i++) tbl[i] = mk(3'b111, 3'b100, 2'd2, 16'hC222, 1'b1);
    tbl[19] = mk(3'b111, 3'b000, 2'd2, 16'hC222, 1'b0);
    tbl[20] = mk(3'b111, 3'b000, 2'd2, 16'hC222, 1'b0);
    tbl[21] = mk(3'b111, 3'b001, 2'd0, 16'hC222, 1'b1);
    tbl[22] = mk(3'b111, 3'b001, 2'd0, 16'hA000, 1'b1);

    do_reset();
    for (int i = 0; i < 23; i++) begin
      req = tbl[i].req;
      tick();
      chk_all($sformatf("rot[%0d]", i), tbl[i].g, tbl[i].o, tbl[i].d, tbl[i].en);
    end

    // Sole requester keeps the display indefinitely.
    do_reset();
    req = 3'b010;
    for (int i = 0; i < 100; i++) begin
      tick();
      chk("solo.grant", {13'd0, grant}, 16'd2);
      chk("solo.en", {15'd0, disp_enable}, 16'd1);
      if (i > 0) chk("solo.data", disp_data, 16'hB111);
    end

    // One-edge latency from data input to display.
    data1 = 16'h1234;
    tick();
    chk("lat.1234", disp_data, 16'h1234);
    data1 = 16'hBEEF;
    #1;
    chk("lat.before", disp_data, 16'h1234);
    tick();
    chk("lat.beef", disp_data, 16'hBEEF);

    // Asynchronous reset mid-grant, then arbitration restarts at requester 0.
    reset = 1'b0;
    #1;
    chk_all("areset", 3'b000, 2'd2, 16'h0000, 1'b0);
    #2;
    reset = 1'b1;
    req = 3'b111;
    tick();
    chk("areset.rel.grant", {13'd0, grant}, 16'd1);
    data1 = 16'hB111;

    // Owner drop early in tenure; non-owner churn is invisible.
    do_reset();
    req = 3'b101;
    tick();
    chk_all("drop.e1", 3'b001, 2'd0, 16'h0000, 1'b1);
    req = 3'b111;
    tick();
    chk_all("drop.e2", 3'b001, 2'd0, 16'hA000, 1'b1);
    req = 3'b100;
    tick();
    chk_all("drop.e3", 3'b000, 2'd0, 16'hA000, 1'b0);
    data0 = 16'h5555;
    tick();
    chk_all("drop.e4", 3'b000, 2'd0, 16'hA000, 1'b0);
    tick();
    chk_all("drop.e5", 3'b100, 2'd2, 16'hA000, 1'b1);
    tick();
    chk_all("drop.e6", 3'b100, 2'd2, 16'hC222, 1'b1);
    data0 = 16'hA000;

    // Mid-blank requests ignored; final blank edge sample decides.
    req = 3'b000;
    tick();
    chk_all("blk.a", 3'b000, 2'd2, 16'hC222, 1'b0);
    req = 3'b001;
    tick();
    chk_all("blk.b", 3'b000, 2'd2, 16'hC222, 1'b0);
    req = 3'b010;
    tick();
    chk_all("blk.c", 3'b010, 2'd1, 16'hC222, 1'b1);
    tick();
    chk_all("blk.d", 3'b010, 2'd1, 16'hB111, 1'b1);
    req = 3'b000;
    tick();
    tick();
    tick();
    chk_all("idle.a", 3'b000, 2'd1, 16'hB111, 1'b0);
    tick();
    chk_all("idle.b", 3'b000, 2'd1, 16'hB111, 1'b0);
    req = 3'b100;
    tick();
    chk_all("idle.c", 3'b100, 2'd2, 16'hB111, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
